// File: rtl/pattern_counter_pkg.sv
// Shared definitions for the pattern counter: report-slot states and the
// detector's match-flag bit positions.
package pattern_counter_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  localparam int unsigned MATCH_W   = 2;
  localparam int unsigned MATCH_111 = 0;
  localparam int unsigned MATCH_001 = 1;

endpackage : pattern_counter_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a synchronous clear wins over increment.
module sat_counter
  import pattern_counter_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : sat_counter

// File: rtl/pattern_counter.sv
// Counts detector hits per fixed window and offers each window's totals as a
// single-entry report; a window closing onto an untaken report is dropped.
module pattern_counter
  import pattern_counter_pkg::*;
#(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned SEQ_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [MATCH_W-1:0] match_in,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [CNT_W-1:0]   report_count0,
  output logic [CNT_W-1:0]   report_count1,
  output logic [SEQ_W-1:0]   report_seq,
  output logic               overrun,
  output logic [CNT_W-1:0]   drop_count
);

  localparam int unsigned CYC_W = $clog2(WINDOW);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(WINDOW - 1);

  logic [CYC_W-1:0] cyc_q,  cyc_d;
  logic [SEQ_W-1:0] wseq_q, wseq_d;
  slot_e            slot_q, slot_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [SEQ_W-1:0] seq_q,  seq_d;
  logic             overrun_q, overrun_d;

  logic             close;
  logic             load;
  logic             drop;
  logic [CNT_W-1:0] acc0, acc1;
  logic [CNT_W-1:0] acc0_fin, acc1_fin;
  logic [CNT_W-1:0] drop_cnt;

  sat_counter #(.W(CNT_W)) u_acc0 (
    .clock (clock),
    .reset (reset),
    .clear (close),
    .inc   (match_in[MATCH_111]),
    .q     (acc0)
  );

  sat_counter #(.W(CNT_W)) u_acc1 (
    .clock (clock),
    .reset (reset),
    .clear (close),
    .inc   (match_in[MATCH_001]),
    .q     (acc1)
  );

  sat_counter #(.W(CNT_W)) u_drop (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .inc   (drop),
    .q     (drop_cnt)
  );

  // Window position and sequence number; every close advances the sequence.
  always_comb begin
    close  = (cyc_q == LAST_CYC);
    cyc_d  = close ? '0 : cyc_q + CYC_W'(1);
    wseq_d = close ? wseq_q + SEQ_W'(1) : wseq_q;
  end

  // The accumulators clear on close, so fold in the closing cycle's flag here.
  always_comb begin
    acc0_fin = (match_in[MATCH_111] && (acc0 != '1)) ? acc0 + CNT_W'(1) : acc0;
    acc1_fin = (match_in[MATCH_001] && (acc1 != '1)) ? acc1 + CNT_W'(1) : acc1;
  end

  // Report slot: reload on close when free or being taken, else drop.
  always_comb begin
    slot_d    = slot_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    seq_d     = seq_q;
    overrun_d = overrun_q;
    load      = 1'b0;
    drop      = 1'b0;

    unique case (slot_q)
      SLOT_EMPTY: begin
        if (close) begin
          load   = 1'b1;
          slot_d = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (close) begin
          if (report_ready) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (report_ready) begin
          slot_d = SLOT_EMPTY;
        end
      end
    endcase

    if (load) begin
      cnt0_d = acc0_fin;
      cnt1_d = acc1_fin;
      seq_d  = wseq_q;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q     <= '0;
      wseq_q    <= '0;
      slot_q    <= SLOT_EMPTY;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      seq_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      wseq_q    <= wseq_d;
      slot_q    <= slot_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      seq_q     <= seq_d;
      overrun_q <= overrun_d;
    end
  end

  assign report_valid  = (slot_q == SLOT_FULL);
  assign report_count0 = cnt0_q;
  assign report_count1 = cnt1_q;
  assign report_seq    = seq_q;
  assign overrun       = overrun_q;
  assign drop_count    = drop_cnt;

endmodule : pattern_counter

// File: tb/tb_pattern_counter.sv
// Self-checking bench for pattern_counter: directed scenarios plus randomized
// traffic against a window-level behavioural model.
module tb_pattern_counter;

  localparam int unsigned WINDOW   = 16;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SEQ_W    = 4;
  localparam int unsigned S_WINDOW = 32;
  localparam int unsigned S_CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset;
  logic [1:0]       match_in;
  logic             report_ready;
  logic             report_valid;
  logic [CNT_W-1:0] report_count0, report_count1, drop_count;
  logic [SEQ_W-1:0] report_seq;
  logic             overrun;

  logic [1:0]         s_match;
  logic               s_ready;
  logic               s_valid, s_over;
  logic [S_CNT_W-1:0] s_count0, s_count1, s_drop;
  logic [SEQ_W-1:0]   s_seq;

  pattern_counter #(.WINDOW(WINDOW), .CNT_W(CNT_W), .SEQ_W(SEQ_W)) dut (
    .clock(clock), .reset(reset), .match_in(match_in),
    .report_valid(report_valid), .report_ready(report_ready),
    .report_count0(report_count0), .report_count1(report_count1),
    .report_seq(report_seq), .overrun(overrun), .drop_count(drop_count)
  );

  pattern_counter #(.WINDOW(S_WINDOW), .CNT_W(S_CNT_W), .SEQ_W(SEQ_W)) dut_sat (
    .clock(clock), .reset(reset), .match_in(s_match),
    .report_valid(s_valid), .report_ready(s_ready),
    .report_count0(s_count0), .report_count1(s_count1),
    .report_seq(s_seq), .overrun(s_over), .drop_count(s_drop)
  );

  int checks = 0;
  int errors = 0;

  // Model: position in window, raw hit totals, and a one-deep report slot.
  int m_pos = 0, m_a0 = 0, m_a1 = 0, m_wseq = 0, m_drops = 0;
  int m_c0 = 0, m_c1 = 0, m_seq = 0;
  bit m_valid = 0, m_over = 0;

  task automatic model_step(input logic [1:0] m, input logic r, input logic rs);
    bit closing;
    if (rs) begin
      m_pos = 0; m_a0 = 0; m_a1 = 0; m_wseq = 0; m_drops = 0;
      m_c0 = 0; m_c1 = 0; m_seq = 0; m_valid = 0; m_over = 0;
    end else begin
      m_a0 += int'(m[0]);
      m_a1 += int'(m[1]);
      closing = (m_pos == int'(WINDOW) - 1);
      if (m_valid && r) m_valid = 0;
      if (closing) begin
        if (!m_valid) begin
          m_valid = 1;
          m_c0 = (m_a0 > CNT_MAX) ? CNT_MAX : m_a0;
          m_c1 = (m_a1 > CNT_MAX) ? CNT_MAX : m_a1;
          m_seq = m_wseq % (1 << SEQ_W);
        end else begin
          m_over = 1;
          m_drops++;
        end
        m_wseq++;
        m_a0 = 0; m_a1 = 0; m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  // Drive one cycle's inputs, take the edge, update the model, settle.
  task automatic tick(input logic [1:0] m, input logic r, input logic rs);
    match_in = m; report_ready = r; reset = rs;
    @(posedge clock);
    model_step(m, r, rs);
    #1;
  endtask

  task automatic test_reset;
    int early = 0;
    for (int i = 0; i < 3; i++) tick(2'b11, 1'b0, 1'b1);
    checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", report_valid); end
    checks++; if (report_count0 !== '0) begin errors++; $display("FAIL reset_count0: got %0d expected 0", report_count0); end
    checks++; if (report_count1 !== '0) begin errors++; $display("FAIL reset_count1: got %0d expected 0", report_count1); end
    checks++; if (report_seq !== '0) begin errors++; $display("FAIL reset_seq: got %0d expected 0", report_seq); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0d expected 0", overrun); end
    checks++; if (drop_count !== '0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    for (int k = 0; k < 16; k++) begin
      tick(2'b00, 1'b0, 1'b0);
      if (k < 15 && report_valid !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL reset_early_valid: got %0d early cycles expected 0", early); end
    checks++; if (report_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %0d expected 1", report_valid); end
  endtask

  task automatic test_basic_count;
    logic [1:0] m;
    tick(2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      m = (k < 3) ? 2'b01 : ((k == 15) ? 2'b10 : 2'b00);
      tick(m, 1'b1, 1'b0);
    end
    checks++; if (report_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0d expected 1", report_valid); end
    checks++; if (report_count0 !== 8'd3) begin errors++; $display("FAIL basic_count0: got %0d expected 3", report_count0); end
    checks++; if (report_count1 !== 8'd1) begin errors++; $display("FAIL basic_count1: got %0d expected 1", report_count1); end
    checks++; if (report_seq !== 4'd0) begin errors++; $display("FAIL basic_seq: got %0d expected 0", report_seq); end
    tick(2'b00, 1'b1, 1'b0);
    checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got %0d expected 0", report_valid); end
  endtask

  task automatic test_saturation;
    tick(2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 32; k++) tick(2'b00, 1'b0, 1'b0);
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %0d expected 1", s_valid); end
    checks++; if (s_count0 !== 4'd15) begin errors++; $display("FAIL sat_count0: got %0d expected 15", s_count0); end
    checks++; if (s_count1 !== 4'd15) begin errors++; $display("FAIL sat_count1: got %0d expected 15", s_count1); end
  endtask

  task automatic test_backpressure;
    logic [1:0] m;
    int sum0 = 0, sum1 = 0, unstable = 0;
    tick(2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      m = 2'($urandom_range(0, 3));
      if (k < 16) begin sum0 += int'(m[0]); sum1 += int'(m[1]); end
      tick(m, 1'b0, 1'b0);
      if (k > 15 && (report_valid !== 1'b1 || int'(report_count0) != sum0 ||
                     int'(report_count1) != sum1 || report_seq !== 4'd0)) unstable++;
      if (k == 15) begin
        checks++; if (int'(report_count0) != sum0 || int'(report_count1) != sum1) begin
          errors++; $display("FAIL bp_counts: got %0d/%0d expected %0d/%0d", report_count0, report_count1, sum0, sum1);
        end
      end
      if (k == 31) begin
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %0d expected 1", overrun); end
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL bp_drop: got %0d expected 1", drop_count); end
      end
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
    tick(2'b00, 1'b1, 1'b0);
    checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL bp_accept: got %0d expected 0", report_valid); end
    for (int k = 41; k < 48; k++) tick(2'b00, 1'b1, 1'b0);
    checks++; if (report_valid !== 1'b1 || report_seq !== 4'd2) begin
      errors++; $display("FAIL bp_next_seq: got valid=%0d seq=%0d expected valid=1 seq=2", report_valid, report_seq);
    end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL bp_drop_hold: got %0d expected 1", drop_count); end
  endtask

  task automatic test_back_to_back;
    tick(2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 32; k++) tick(2'($urandom_range(0, 3)), (k == 31), 1'b0);
    checks++; if (report_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0d expected 1", report_valid); end
    checks++; if (report_seq !== 4'd1) begin errors++; $display("FAIL b2b_seq: got %0d expected 1", report_seq); end
    checks++; if (drop_count !== 8'd0 || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_no_drop: got drop=%0d overrun=%0d expected 0/0", drop_count, overrun);
    end
    checks++; if (int'(report_count0) != m_c0 || int'(report_count1) != m_c1) begin
      errors++; $display("FAIL b2b_counts: got %0d/%0d expected %0d/%0d", report_count0, report_count1, m_c0, m_c1);
    end
  endtask

  task automatic test_reset_mid_window;
    logic [1:0] m;
    tick(2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) tick((k < 5) ? 2'b01 : 2'b00, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      m = (k == 3 || k == 9) ? 2'b01 : ((k == 12) ? 2'b10 : 2'b00);
      tick(m, 1'b0, 1'b0);
      if (k == 14) begin
        checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL rmid_early: got %0d expected 0", report_valid); end
      end
    end
    checks++; if (report_valid !== 1'b1 || report_seq !== 4'd0) begin
      errors++; $display("FAIL rmid_report: got valid=%0d seq=%0d expected valid=1 seq=0", report_valid, report_seq);
    end
    checks++; if (report_count0 !== 8'd2 || report_count1 !== 8'd1) begin
      errors++; $display("FAIL rmid_counts: got %0d/%0d expected 2/1", report_count0, report_count1);
    end
  endtask

  task automatic test_random;
    logic [1:0] m;
    logic r, rs;
    int pct;
    int exp_drop;
    tick(2'b00, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      pct = ((n / 500) % 3 == 0) ? 5 : (((n / 500) % 3 == 1) ? 50 : 95);
      m  = 2'($urandom_range(0, 3));
      r  = ($urandom_range(0, 99) < pct);
      rs = ($urandom_range(0, 399) == 0);
      tick(m, r, rs);
      exp_drop = (m_drops > CNT_MAX) ? CNT_MAX : m_drops;
      checks++; if (report_valid !== m_valid) begin
        errors++; $display("FAIL rand_valid @%0d: got %0d expected %0d", n, report_valid, m_valid);
      end
      checks++; if (overrun !== m_over || int'(drop_count) != exp_drop) begin
        errors++; $display("FAIL rand_drop @%0d: got overrun=%0d drop=%0d expected %0d/%0d", n, overrun, drop_count, m_over, exp_drop);
      end
      if (m_valid) begin
        checks++; if (int'(report_count0) != m_c0 || int'(report_count1) != m_c1 || int'(report_seq) != m_seq) begin
          errors++; $display("FAIL rand_report @%0d: got %0d/%0d seq %0d expected %0d/%0d seq %0d",
                             n, report_count0, report_count1, report_seq, m_c0, m_c1, m_seq);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; match_in = 2'b00; report_ready = 1'b0;
    s_match = 2'b11; s_ready = 1'b1;
    test_reset();
    test_basic_count();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_window();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pattern_counter
